// File: rtl/apb_timer_mc_unit_if.sv
// APB slave bus bundle for apb_timer_mc_unit; the fabric side uses the master modport.
interface apb_timer_mc_unit_if #(
  parameter int ADDR_W = 12
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [31:0]       PWDATA;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_timer_mc_unit.sv
// NUM_CH-channel APB timer: prescaled up-counters with compare match and level interrupts.
// Define APB_TIMER_MC_CASCADE_EN to make mode 11 count matches of the previous channel.
module apb_timer_mc_unit #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 8,
  parameter int ADDR_W  = 12
) (
  input  logic               HCLK,
  input  logic               HRESET,
  apb_timer_mc_unit_if.slave apb,
  input  logic               stoptimer_i,
  input  logic [NUM_CH-1:0]  event_i,
  input  logic               ref_tick_i,
  output logic [NUM_CH-1:0]  irq_o,
  output logic               busy_o
);
  typedef enum logic [1:0] {
    MODE_CONT    = 2'b00,
    MODE_ONESHOT = 2'b01,
    MODE_EVENT   = 2'b10,
    MODE_CASCADE = 2'b11
  } mode_e;

  logic [NUM_CH-1:0]  en_q, en_d, src_q, src_d, irqEn_q, irqEn_d, stat_q, stat_d;
  mode_e              mode_q  [NUM_CH];
  mode_e              mode_d  [NUM_CH];
  logic [PRESC_W-1:0] presc_q [NUM_CH];
  logic [PRESC_W-1:0] presc_d [NUM_CH];
  logic [PRESC_W-1:0] pcnt_q  [NUM_CH];
  logic [PRESC_W-1:0] pcnt_d  [NUM_CH];
  logic [CNT_W-1:0]   cnt_q   [NUM_CH];
  logic [CNT_W-1:0]   cnt_d   [NUM_CH];
  logic [CNT_W-1:0]   cmp_q   [NUM_CH];
  logic [CNT_W-1:0]   cmp_d   [NUM_CH];

  logic              refSync_q, refPrev_q, busy_q;
  logic [NUM_CH-1:0] evSync_q, evPrev_q;
  logic              refRise;
  logic [NUM_CH-1:0] evRise;

  logic [31:0] chSel, rdData;
  logic [3:0]  off;
  logic        access, decErr, wrEn;

  assign chSel   = 32'(apb.PADDR[ADDR_W-1:4]);
  assign off     = apb.PADDR[3:0];
  assign access  = apb.PSEL & apb.PENABLE;
  assign decErr  = (chSel >= 32'(NUM_CH)) || (off[1:0] != 2'b00);
  assign wrEn    = access & apb.PWRITE & ~decErr;
  assign refRise = refSync_q & ~refPrev_q;
  assign evRise  = evSync_q & ~evPrev_q;

  // Per-channel next state; later assignments win, which orders the collision rules.
  always_comb begin
    logic tick, inc, hit, wrCh;
`ifdef APB_TIMER_MC_CASCADE_EN
    logic prevMatch;
    prevMatch = 1'b0;
`endif
    for (int c = 0; c < NUM_CH; c++) begin
      en_d[c]    = en_q[c];
      mode_d[c]  = mode_q[c];
      src_d[c]   = src_q[c];
      irqEn_d[c] = irqEn_q[c];
      presc_d[c] = presc_q[c];
      pcnt_d[c]  = pcnt_q[c];
      cnt_d[c]   = cnt_q[c];
      cmp_d[c]   = cmp_q[c];
      stat_d[c]  = stat_q[c];
      wrCh       = wrEn && (chSel == 32'(c));

      case (mode_q[c])
        MODE_EVENT:   tick = evRise[c];
        MODE_CASCADE: tick = 1'b0;
        default:      tick = src_q[c] ? refRise : 1'b1;
      endcase

      inc = 1'b0;
      if (!en_q[c]) begin
        pcnt_d[c] = '0;
      end else if (!stoptimer_i) begin
        if (mode_q[c] == MODE_CASCADE) begin
`ifdef APB_TIMER_MC_CASCADE_EN
          inc = prevMatch;
`endif
        end else if (tick) begin
          if (pcnt_q[c] == presc_q[c]) begin
            pcnt_d[c] = '0;
            inc       = 1'b1;
          end else begin
            pcnt_d[c] = pcnt_q[c] + 1'b1;
          end
        end
      end

      hit = inc && (cnt_q[c] == cmp_q[c]);
      if (inc) begin
        cnt_d[c] = hit ? '0 : cnt_q[c] + 1'b1;
      end
      if (hit && mode_q[c] == MODE_ONESHOT) begin
        en_d[c] = 1'b0;
      end

      if (wrCh) begin
        case (off)
          4'h0: begin
            en_d[c]    = apb.PWDATA[0];
            mode_d[c]  = mode_e'(apb.PWDATA[2:1]);
            src_d[c]   = apb.PWDATA[3];
            irqEn_d[c] = apb.PWDATA[4];
            presc_d[c] = apb.PWDATA[8 +: PRESC_W];
          end
          4'h4:    cnt_d[c] = apb.PWDATA[CNT_W-1:0];
          4'h8:    cmp_d[c] = apb.PWDATA[CNT_W-1:0];
          4'hC:    if (apb.PWDATA[0]) stat_d[c] = 1'b0;
          default: ;
        endcase
      end
      if (hit) begin
        stat_d[c] = 1'b1;
      end
`ifdef APB_TIMER_MC_CASCADE_EN
      prevMatch = hit;
`endif
    end
  end

  always_comb begin
    rdData = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (chSel == 32'(c)) begin
        case (off)
          4'h0:    rdData = 32'({presc_q[c], 3'b000, irqEn_q[c], src_q[c], mode_q[c], en_q[c]});
          4'h4:    rdData = 32'(cnt_q[c]);
          4'h8:    rdData = 32'(cmp_q[c]);
          4'hC:    rdData = {31'd0, stat_q[c]};
          default: rdData = '0;
        endcase
      end
    end
  end

  assign apb.PRDATA  = (access && !decErr) ? rdData : '0;
  assign apb.PSLVERR = access & decErr;
  assign apb.PREADY  = 1'b1;
  assign irq_o       = stat_q & irqEn_q;
  assign busy_o      = busy_q;

  // Edge-detect pipeline keeps sampling while frozen so a resume does not see stale edges.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      en_q      <= '0;
      src_q     <= '0;
      irqEn_q   <= '0;
      stat_q    <= '0;
      refSync_q <= 1'b0;
      refPrev_q <= 1'b0;
      evSync_q  <= '0;
      evPrev_q  <= '0;
      busy_q    <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        mode_q[c]  <= MODE_CONT;
        presc_q[c] <= '0;
        pcnt_q[c]  <= '0;
        cnt_q[c]   <= '0;
        cmp_q[c]   <= '0;
      end
    end else begin
      en_q      <= en_d;
      src_q     <= src_d;
      irqEn_q   <= irqEn_d;
      stat_q    <= stat_d;
      refSync_q <= ref_tick_i;
      refPrev_q <= refSync_q;
      evSync_q  <= event_i;
      evPrev_q  <= evSync_q;
      busy_q    <= (|en_q) & ~stoptimer_i;
      for (int c = 0; c < NUM_CH; c++) begin
        mode_q[c]  <= mode_d[c];
        presc_q[c] <= presc_d[c];
        pcnt_q[c]  <= pcnt_d[c];
        cnt_q[c]   <= cnt_d[c];
        cmp_q[c]   <= cmp_d[c];
      end
    end
  end
endmodule

// File: tb/tb_apb_timer_mc_unit.sv
// Scoreboard bench for apb_timer_mc_unit: read expectations are queued at drive time
// and popped when the access-phase data is sampled.
module tb_apb_timer_mc_unit;
`ifdef APB_TIMER_MC_CASCADE_EN
  localparam bit CASCADE = 1'b1;
`else
  localparam bit CASCADE = 1'b0;
`endif

  logic       HCLK = 1'b0;
  logic       HRESET;
  logic       stoptimer_i;
  logic [3:0] event_i;
  logic       ref_tick_i;
  logic [3:0] irq_o;
  logic       busy_o;

  int checks   = 0;
  int failures = 0;

  logic [31:0] expQ[$];
  logic        errQ[$];
  string       tagQ[$];

  apb_timer_mc_unit_if #(.ADDR_W(12)) apb ();

  apb_timer_mc_unit #(.NUM_CH(4), .CNT_W(32), .PRESC_W(8), .ADDR_W(12)) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .apb         (apb),
    .stoptimer_i (stoptimer_i),
    .event_i     (event_i),
    .ref_tick_i  (ref_tick_i),
    .irq_o       (irq_o),
    .busy_o      (busy_o)
  );

  always #5 HCLK = ~HCLK;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  task automatic apbWrite(input logic [11:0] addr, input logic [31:0] data);
    @(posedge HCLK); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1; apb.PADDR = addr; apb.PWDATA = data;
    @(posedge HCLK); #1;
    apb.PENABLE = 1'b1;
    @(posedge HCLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
  endtask

  task automatic apbRead(input string tag, input logic [11:0] addr, input logic [31:0] expData, input logic expErr);
    @(posedge HCLK); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = addr;
    @(posedge HCLK); #1;
    apb.PENABLE = 1'b1;
    expQ.push_back(expData); errQ.push_back(expErr); tagQ.push_back(tag);
    @(negedge HCLK);
    begin
      string t;
      t = tagQ.pop_front();
      checkOutput({t, ".data"}, apb.PRDATA, expQ.pop_front());
      checkOutput({t, ".err"}, 32'(apb.PSLVERR), 32'(errQ.pop_front()));
    end
    @(posedge HCLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
  endtask

  // Opens the freeze for exactly n clock edges, so n ticks reach the enabled channels.
  task automatic applyStimulus(input int n);
    @(posedge HCLK); #1;
    stoptimer_i = 1'b0;
    repeat (n) @(posedge HCLK);
    #1 stoptimer_i = 1'b1;
  endtask

  task automatic evPulse(input int hold);
    @(posedge HCLK); #1 event_i[2] = 1'b1;
    repeat (hold) @(posedge HCLK);
    #1 event_i[2] = 1'b0;
    repeat (3) @(posedge HCLK);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    HRESET = 1'b1; stoptimer_i = 1'b1; event_i = '0; ref_tick_i = 1'b0;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = '0; apb.PWDATA = '0;
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;
    @(negedge HCLK);
    checkOutput("rst.irq", 32'(irq_o), 32'h0);
    checkOutput("rst.busy", 32'(busy_o), 32'h0);
    checkOutput("rst.pready", 32'(apb.PREADY), 32'h1);
    checkOutput("rst.idleRd", apb.PRDATA, 32'h0);
    apbRead("rst.ctrl0", 12'h000, 32'h0, 1'b0);
    apbRead("rst.cnt0", 12'h004, 32'h0, 1'b0);
    apbRead("rst.cmp3", 12'h038, 32'h0, 1'b0);
    apbRead("rst.stat0", 12'h00C, 32'h0, 1'b0);

    $display("[TB] ch0 continuous, CMP=4");
    apbWrite(12'h008, 32'd4);
    apbWrite(12'h000, 32'h11);
    checkOutput("c0.busyFrozen", 32'(busy_o), 32'h0);
    applyStimulus(4);
    apbRead("c0.cnt4", 12'h004, 32'd4, 1'b0);
    checkOutput("c0.irqBefore", 32'(irq_o), 32'h0);
    applyStimulus(1);
    apbRead("c0.cntWrap", 12'h004, 32'd0, 1'b0);
    apbRead("c0.stat", 12'h00C, 32'd1, 1'b0);
    checkOutput("c0.irq", 32'(irq_o), 32'h1);
    applyStimulus(3);
    apbWrite(12'h00C, 32'd1);
    checkOutput("c0.irqClr", 32'(irq_o), 32'h0);
    apbRead("c0.statClr", 12'h00C, 32'd0, 1'b0);
    apbRead("c0.cnt3", 12'h004, 32'd3, 1'b0);

    $display("[TB] freeze holds counter and prescaler");
    apbWrite(12'h000, 32'h111);
    apbWrite(12'h008, 32'd100);
    apbWrite(12'h004, 32'd0);
    applyStimulus(5);
    repeat (10) @(posedge HCLK);
    @(negedge HCLK);
    checkOutput("frz.busy", 32'(busy_o), 32'h0);
    apbRead("frz.cnt", 12'h004, 32'd2, 1'b0);
    apbWrite(12'h008, 32'd50);
    apbRead("frz.cmp", 12'h008, 32'd50, 1'b0);
    applyStimulus(1);
    apbRead("frz.resume", 12'h004, 32'd3, 1'b0);

    $display("[TB] collisions");
    apbWrite(12'h000, 32'h11);
    stoptimer_i = 1'b0;
    apbWrite(12'h004, 32'd7);
    stoptimer_i = 1'b1;
    apbRead("col.cntWr", 12'h004, 32'd7, 1'b0);
    apbWrite(12'h008, 32'd0);
    apbWrite(12'h004, 32'd0);
    stoptimer_i = 1'b0;
    apbWrite(12'h00C, 32'd1);
    stoptimer_i = 1'b1;
    apbRead("col.statKept", 12'h00C, 32'd1, 1'b0);
    apbRead("col.cmp0Cnt", 12'h004, 32'd0, 1'b0);
    checkOutput("col.irq", 32'(irq_o), 32'h1);
    apbWrite(12'h00C, 32'd1);
    apbRead("col.statW1c", 12'h00C, 32'd0, 1'b0);
    apbWrite(12'h000, 32'h0);

    $display("[TB] ch1 one-shot, presc 3");
    apbWrite(12'h018, 32'd2);
    apbWrite(12'h010, 32'h303);
    applyStimulus(11);
    apbRead("os.cnt11", 12'h014, 32'd2, 1'b0);
    apbRead("os.ctrl11", 12'h010, 32'h303, 1'b0);
    @(posedge HCLK); #1 stoptimer_i = 1'b0;
    @(posedge HCLK);
    @(negedge HCLK) checkOutput("os.busyMatch", 32'(busy_o), 32'h1);
    @(posedge HCLK);
    @(negedge HCLK) checkOutput("os.busyFall", 32'(busy_o), 32'h0);
    stoptimer_i = 1'b1;
    apbRead("os.ctrlDone", 12'h010, 32'h302, 1'b0);
    apbRead("os.stat", 12'h01C, 32'd1, 1'b0);
    applyStimulus(8);
    apbRead("os.cntHold", 12'h014, 32'd0, 1'b0);

    $display("[TB] ch2 event count");
    apbWrite(12'h028, 32'd1);
    apbWrite(12'h020, 32'h5);
    stoptimer_i = 1'b0;
    evPulse(1);
    apbRead("ev.cnt1", 12'h024, 32'd1, 1'b0);
    evPulse(1);
    apbRead("ev.cntMatch", 12'h024, 32'd0, 1'b0);
    apbRead("ev.stat", 12'h02C, 32'd1, 1'b0);
    evPulse(1);
    apbRead("ev.cnt3", 12'h024, 32'd1, 1'b0);
    apbWrite(12'h028, 32'd5);
    evPulse(10);
    apbRead("ev.level", 12'h024, 32'd2, 1'b0);
    stoptimer_i = 1'b1;
    apbWrite(12'h020, 32'h0);

    $display("[TB] decode errors");
    apbRead("err.ch4", 12'h040, 32'h0, 1'b1);
    apbRead("err.align", 12'h002, 32'h0, 1'b1);
    apbWrite(12'h044, 32'd9);
    apbRead("err.dropWr", 12'h004, 32'd0, 1'b0);

    $display("[TB] mode 11 chain ch0 -> ch1");
    apbWrite(12'h004, 32'd0);
    apbWrite(12'h00C, 32'd1);
    apbWrite(12'h008, 32'd1);
    apbWrite(12'h014, 32'd0);
    apbWrite(12'h01C, 32'd1);
    apbWrite(12'h018, 32'd2);
    apbWrite(12'h010, 32'h7);
    apbWrite(12'h000, 32'h1);
    apbRead("cas.ctrl1", 12'h010, 32'h7, 1'b0);
    applyStimulus(5);
    apbRead("cas.cnt1at5", 12'h014, CASCADE ? 32'd2 : 32'd0, 1'b0);
    apbRead("cas.stat1at5", 12'h01C, 32'd0, 1'b0);
    applyStimulus(1);
    apbRead("cas.cnt0at6", 12'h004, 32'd0, 1'b0);
    apbRead("cas.cnt1at6", 12'h014, 32'd0, 1'b0);
    apbRead("cas.stat1at6", 12'h01C, CASCADE ? 32'd1 : 32'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
